ex_jalr_redirect_stage: RTL
===========================

// Module: ex_jalr_redirect_stage
// PURPOSE
// EX-stage JALR resolver sitting directly upstream of the EX/JALR pipeline register.
// Computes target = (rs1+imm)&~1 and link = pc+4, and fills the EX/JALR register via valid/ready.
// Raises a held fetch redirect and flushes younger instructions for FLUSH_DEPTH cycles.
// Misaligned targets raise an exception instead of redirecting.
// PARAMETERS
// XLEN         32  datapath width
// FLUSH_DEPTH  2   cycles of flush after redirect/exception ack (>=1)
// C_EXT        0   1: IALIGN=16, no misalign check; 0: target[1]=1 is misaligned
// PORTS
// Clock          in   1     single clock; all state on posedge
// Reset          in   1     synchronous, active-low
// Tick           in   1     global advance enable; Tick=0 holds all state and outputs
// in_valid       in   1     ID/EX offers an instruction
// in_ready       out  1     stage accepts (in_valid&in_ready&Tick)
// in_is_jalr     in   1     offered instruction is JALR; else pass-through
// in_pc          in   XLEN  instruction PC
// in_rs1         in   XLEN  rs1 operand (forwarded)
// in_imm         in   XLEN  sign-extended I-immediate
// in_rd          in   5     destination register
// out_valid      out  1     entry valid toward EX/JALR register
// out_ready      in   1     EX/JALR register accepts
// out_rd         out  5     rd of held entry
// out_link       out  XLEN  pc+4 (JALR) or in_rs1 pass-through (other)
// out_target     out  XLEN  computed target (0 for non-JALR)
// redirect_req   out  1     fetch redirect request, held until ack
// redirect_pc    out  XLEN  redirect address
// redirect_ack   in   1     fetch accepted redirect
// flush          out  1     squash younger IF/ID instructions
// exc_req        out  1     misaligned-target exception, held until ack
// exc_tval       out  XLEN  faulting target
// exc_ack        in   1     trap unit accepted exception
// BEHAVIOUR
// - Reset (Reset=0 at posedge, overrides Tick): state=IDLE; every output 0; in_ready=1 next cycle.
// - States: IDLE, REDIR, EXC, FLUSH; 2-bit encoding from shared package.
// - in_ready = (state==IDLE) & (~out_valid | out_ready); combinational, no in_valid dependence.
// - Accept (IDLE, handshake): latency 1 -> out_valid/redirect_req/exc_req rise next cycle.
//   non-JALR: load out entry, stay IDLE.
//   JALR aligned: load entry (link=pc+4, target), redirect_pc=target, redirect_req=1, ->REDIR.
//   JALR misaligned (C_EXT=0 & target[1]): no out entry (rd not written), exc_tval=target,
//     exc_req=1, ->EXC.
// - REDIR: redirect_req held; redirect_ack ->FLUSH, req drops same edge. Ack while req=0 ignored.
// - EXC: exc_req held; exc_ack ->FLUSH, req drops.
// - FLUSH: flush=1 for exactly FLUSH_DEPTH cycles (counter, Tick-gated), then IDLE.
// - Output entry: out_valid clears on out_ready unless reloaded that cycle.
//   Load and drain in the same cycle are legal; no bubble when in_ready is high.
// - Arithmetic mod 2^XLEN; bit0 of target always 0. Example: rs1=FFFF_FFFF + imm=1 -> 0.
//   pc=FFFF_FFFC -> link 0.
// - Simultaneous ack and Tick=0: ack ignored; fetch must hold ack until a Tick cycle.
// - Reset mid-REDIR/EXC/FLUSH: request and flush drop at that edge; pending entry discarded.
// STRUCTURE
// - Shared package/header: XLEN default, state encodings, JALR opcode/funct3 constants.
// - One sub-module: jalr_target_calc (combinational rs1+imm, clear bit0, misalign flag, pc+4).
// TESTING
// 1 Reset: Reset=0 two cycles -> all outputs 0, then in_ready=1, state IDLE.
// 2 JALR pc=0x100 rs1=0x2000 imm=0x11 -> next cycle out_target=0x2010, out_link=0x104,
//   redirect_req=1; ack after 3 cycles -> flush=1 for 2 cycles, then in_ready=1.
// 3 Misaligned JALR rs1=0x1000 imm=2 (C_EXT=0) -> exc_req=1, exc_tval=0x1002, out_valid=0;
//   exc_ack -> flush 2 cycles; same stimulus with C_EXT=1 -> redirect to 0x1002.
// 4 Backpressure: out_ready=0 with entry held -> in_ready=0, entry stable;
//   back-to-back non-JALR with out_ready=1 -> 1 per cycle, no bubble.
// 5 Wrap: rs1=0xFFFF_FFFF imm=1 -> target 0; pc=0xFFFF_FFFC -> link 0.
// 6 Reset asserted in REDIR and in FLUSH -> redirect_req/flush 0 at next edge, IDLE;
//   Tick=0 during REDIR with ack=1 -> no state change.

Source files
------------

// File: rtl/ex_jalr_redirect_stage_pkg.sv
// Shared constants and FSM encoding for the EX-stage JALR resolver.
// Imported by the resolver top and its target-calculation helper.
package ex_jalr_redirect_stage_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [2:0] F3_JALR  = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REDIR = 2'd1,
    S_EXC   = 2'd2,
    S_FLUSH = 2'd3
  } jalr_state_e;

endpackage

// File: rtl/ex_jalr_redirect_stage_calc.sv
// Combinational JALR target/link arithmetic.
// Target has bit0 cleared; misalignment only matters without compressed ISA.
module jalr_target_calc #(
  parameter int XLEN  = 32,
  parameter bit C_EXT = 1'b0
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] link,
  output logic            misaligned
);

  assign target     = (rs1 + imm) & ~XLEN'(1);
  assign link       = pc + XLEN'(4);
  assign misaligned = !C_EXT && target[1];

endmodule

// File: rtl/ex_jalr_redirect_stage.sv
// EX-stage JALR resolver: fills the EX/JALR register, raises held
// redirect or misalign exception, then flushes younger work.
module ex_jalr_redirect_stage
  import ex_jalr_redirect_stage_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int FLUSH_DEPTH = 2,
  parameter bit C_EXT       = 1'b0
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Tick,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_jalr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_link,
  output logic [XLEN-1:0] out_target,
  output logic            redirect_req,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ack,
  output logic            flush,
  output logic            exc_req,
  output logic [XLEN-1:0] exc_tval,
  input  logic            exc_ack
);

  localparam int CW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

  jalr_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] calc_tgt, calc_link;
  logic            calc_mis;
  logic            acc, drain;

  jalr_target_calc #(
    .XLEN  (XLEN),
    .C_EXT (C_EXT)
  ) u_calc (
    .pc         (in_pc),
    .rs1        (in_rs1),
    .imm        (in_imm),
    .target     (calc_tgt),
    .link       (calc_link),
    .misaligned (calc_mis)
  );

  assign in_ready = Reset && (state_q == S_IDLE)
                 && (!out_valid || out_ready);
  assign acc      = in_valid && in_ready && Tick;
  assign drain    = out_valid && out_ready && Tick;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (Tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (acc && in_is_jalr)
            state_d = calc_mis ? S_EXC : S_REDIR;
        end
        S_REDIR: begin
          if (redirect_ack) begin
            state_d = S_FLUSH;
            cnt_d   = CW'(FLUSH_DEPTH - 1);
          end
        end
        S_EXC: begin
          if (exc_ack) begin
            state_d = S_FLUSH;
            cnt_d   = CW'(FLUSH_DEPTH - 1);
          end
        end
        S_FLUSH: begin
          if (cnt_q == '0) state_d = S_IDLE;
          else             cnt_d   = cnt_q - CW'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    redirect_req = (state_q == S_REDIR);
    exc_req      = (state_q == S_EXC);
    flush        = (state_q == S_FLUSH);
  end

  // Entry register: a load wins over a drain in the same cycle.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      out_valid   <= 1'b0;
      out_rd      <= '0;
      out_link    <= '0;
      out_target  <= '0;
      redirect_pc <= '0;
      exc_tval    <= '0;
    end else if (Tick) begin
      if (acc) begin
        unique case (1'b1)
          !in_is_jalr: begin
            out_valid  <= 1'b1;
            out_rd     <= in_rd;
            out_link   <= in_rs1;
            out_target <= '0;
          end
          in_is_jalr && !calc_mis: begin
            out_valid   <= 1'b1;
            out_rd      <= in_rd;
            out_link    <= calc_link;
            out_target  <= calc_tgt;
            redirect_pc <= calc_tgt;
          end
          in_is_jalr && calc_mis: begin
            out_valid <= 1'b0;
            exc_tval  <= calc_tgt;
          end
        endcase
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
